clk_period_meter: RTL and testbench

- Receive-side counterpart to the board's divided-clock generators.
- Samples an external slow clock or pulse train (e.g. a PMOD JA pin carrying a divided clock) in the CLK100MHZ domain.
- Measures period and high time in 100 MHz cycles and flags loss of signal.
- Results drive LED/seven-segment debug logic and self-checks of the on-board dividers.

---
 rtl/clk_period_meter.sv | 107 ++++++++++
 tb/tb_clk_period_meter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async signal in CLK100MHZ cycles.
// Optional PERIOD_AVG4_EN averages the reported period over the last four captures.
module clk_period_meter #(
    parameter int CNT_W          = 30,
    parameter int TIMEOUT_CYCLES = 300_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             sig_in,
    output logic             sig_level,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic [1:0]             lvl_d;
    logic                   rise, lvl, capture, lose, strobe;
    logic [CNT_W-1:0]       cnt, hcnt, cnt_n, hcnt_n, per_n;

    // Edge detect runs one stage behind sig_level; lvl is the matching level for high-time counting.
    assign sig_level = sync[SYNC_STAGES-1];
    assign lvl       = lvl_d[0];
    assign rise      = lvl_d[0] & ~lvl_d[1];
    assign capture   = (state == S_RUN) && rise;
    assign lose      = (state == S_RUN) && !rise && (cnt == TMO);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync  <= '0;
            lvl_d <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig_in};
            lvl_d <= {lvl_d[0], sig_level};
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = (state == S_IDLE) ? (rise ? S_RUN : S_IDLE) : (lose ? S_IDLE : S_RUN);
    end

    always_comb begin
        cnt_n  = rise ? CNT_W'(1) : (state == S_RUN && !lose) ? cnt + 1'b1 : '0;
        hcnt_n = rise ? CNT_W'(1) : (state == S_RUN && !lose) ? hcnt + CNT_W'(lvl) : '0;
    end

`ifdef PERIOD_AVG4_EN
    logic [2:0][CNT_W-1:0] hist;
    logic [1:0]            ncap;
    logic [CNT_W+1:0]      sum;

    assign sum    = {2'b0, cnt} + {2'b0, hist[0]} + {2'b0, hist[1]} + {2'b0, hist[2]};
    assign per_n  = sum[CNT_W+1:2];
    assign strobe = capture && (ncap == 2'd3);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hist <= '0;
            ncap <= '0;
        end else if (lose) begin
            hist <= '0;
            ncap <= '0;
        end else if (capture) begin
            hist <= {hist[1:0], cnt};
            ncap <= ncap + 2'(ncap != 2'd3);
        end
    end
`else
    assign per_n  = cnt;
    assign strobe = capture;
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            hcnt       <= hcnt_n;
            meas_valid <= strobe;
            if (strobe) begin
                period    <= per_n;
                high_time <= hcnt;
                timeout   <= 1'b0;
            end else if (lose) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of clk_period_meter with TIMEOUT_CYCLES=50, SYNC_STAGES=2.
module tb_clk_period_meter;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        sig_in = 0;
    logic        sig_level, meas_valid, timeout;
    logic [29:0] period, high_time;
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;

    clk_period_meter #(.CNT_W(30), .TIMEOUT_CYCLES(50), .SYNC_STAGES(2)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .sig_in(sig_in), .sig_level(sig_level),
        .period(period), .high_time(high_time), .meas_valid(meas_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (meas_valid === 1'b1) strobes++;

    // One pulse of n cycles, high for the first h, driven on falling edges.
    task automatic pulse(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            sig_in = (i < h);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        sig_in = 0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (period !== 0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
        if (high_time !== 0) begin errors++; $display("FAIL reset_high got %0d want 0", high_time); end
        if (meas_valid !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", meas_valid); end
        if (timeout !== 0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        if (sig_level !== 0) begin errors++; $display("FAIL reset_level got %b want 0", sig_level); end
        rst_n = 1;
        @(negedge clk);
    endtask

`ifdef PERIOD_AVG4_EN
    task automatic test_avg4;
        int s0;
        s0 = strobes;
        pulse(8, 3); pulse(12, 5); pulse(8, 3); pulse(12, 5);
        checks++;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL avg_early_strobes got %0d want 0", strobes - s0); end
        pulse(16, 4);
        checks += 2;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL avg_first_strobes got %0d want 1", strobes - s0); end
        if (period !== 10) begin errors++; $display("FAIL avg_first_period got %0d want 10", period); end
        pulse(10, 4);
        checks += 3;
        if (strobes - s0 !== 2) begin errors++; $display("FAIL avg_second_strobes got %0d want 2", strobes - s0); end
        if (period !== 12) begin errors++; $display("FAIL avg_second_period got %0d want 12", period); end
        if (high_time !== 4) begin errors++; $display("FAIL avg_high got %0d want 4", high_time); end
    endtask
`else
    task automatic test_steady;
        int s0;
        s0 = strobes;
        repeat (4) pulse(10, 4);
        checks += 4;
        if (strobes - s0 !== 3) begin errors++; $display("FAIL steady_strobes got %0d want 3", strobes - s0); end
        if (period !== 10) begin errors++; $display("FAIL steady_period got %0d want 10", period); end
        if (high_time !== 4) begin errors++; $display("FAIL steady_high got %0d want 4", high_time); end
        if (timeout !== 0) begin errors++; $display("FAIL steady_timeout got %b want 0", timeout); end
    endtask

    // Leaves the bench just after edge t+4 with sig_in still high.
    task automatic test_latency;
        sig_in = 1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (meas_valid !== (k == 3)) begin
                errors++;
                $display("FAIL latency_t+%0d got %b want %b", k, meas_valid, k == 3);
            end
        end
        checks += 2;
        if (period !== 10) begin errors++; $display("FAIL latency_period got %0d want 10", period); end
        if (high_time !== 4) begin errors++; $display("FAIL latency_high got %0d want 4", high_time); end
    endtask

    // Internal rise registered at t+3, so timeout must appear at t+53 and not before.
    task automatic test_loss;
        int s0;
        s0 = strobes;
        @(negedge clk);
        sig_in = 0;
        repeat (48) @(posedge clk);
        #1;
        checks++;
        if (timeout !== 0) begin errors++; $display("FAIL loss_early got %b want 0", timeout); end
        @(posedge clk);
        #1;
        checks += 4;
        if (timeout !== 1) begin errors++; $display("FAIL loss_timeout got %b want 1", timeout); end
        if (period !== 10) begin errors++; $display("FAIL loss_period got %0d want 10", period); end
        if (high_time !== 4) begin errors++; $display("FAIL loss_high got %0d want 4", high_time); end
        if (strobes - s0 !== 0) begin errors++; $display("FAIL loss_strobes got %0d want 0", strobes - s0); end
        @(negedge clk);
    endtask

    task automatic test_restart;
        int s0;
        s0 = strobes;
        pulse(10, 3);
        checks += 2;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL restart_rearm_strobes got %0d want 0", strobes - s0); end
        if (timeout !== 1) begin errors++; $display("FAIL restart_rearm_timeout got %b want 1", timeout); end
        pulse(10, 3);
        checks += 4;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL restart_strobes got %0d want 1", strobes - s0); end
        if (period !== 10) begin errors++; $display("FAIL restart_period got %0d want 10", period); end
        if (high_time !== 3) begin errors++; $display("FAIL restart_high got %0d want 3", high_time); end
        if (timeout !== 0) begin errors++; $display("FAIL restart_timeout got %b want 0", timeout); end
    endtask

    task automatic test_boundary;
        int s0;
        pulse(50, 2);
        s0 = strobes;
        pulse(51, 5);
        checks += 4;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL bound50_strobes got %0d want 1", strobes - s0); end
        if (period !== 50) begin errors++; $display("FAIL bound50_period got %0d want 50", period); end
        if (high_time !== 2) begin errors++; $display("FAIL bound50_high got %0d want 2", high_time); end
        if (timeout !== 0) begin errors++; $display("FAIL bound50_timeout got %b want 0", timeout); end
        s0 = strobes;
        pulse(10, 3);
        checks += 3;
        if (timeout !== 1) begin errors++; $display("FAIL bound51_timeout got %b want 1", timeout); end
        if (strobes - s0 !== 0) begin errors++; $display("FAIL bound51_strobes got %0d want 0", strobes - s0); end
        if (period !== 50) begin errors++; $display("FAIL bound51_period got %0d want 50", period); end
    endtask

    task automatic test_reset_mid;
        int s0;
        pulse(10, 3);
        checks++;
        if (period !== 10) begin errors++; $display("FAIL mid_pre_period got %0d want 10", period); end
        #2 rst_n = 0;
        #1;
        checks += 4;
        if (period !== 0) begin errors++; $display("FAIL mid_period got %0d want 0", period); end
        if (high_time !== 0) begin errors++; $display("FAIL mid_high got %0d want 0", high_time); end
        if (meas_valid !== 0) begin errors++; $display("FAIL mid_valid got %b want 0", meas_valid); end
        if (timeout !== 0) begin errors++; $display("FAIL mid_timeout got %b want 0", timeout); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        s0 = strobes;
        pulse(10, 4);
        checks += 2;
        if (strobes - s0 !== 0) begin errors++; $display("FAIL mid_first_strobes got %0d want 0", strobes - s0); end
        if (period !== 0) begin errors++; $display("FAIL mid_first_period got %0d want 0", period); end
        pulse(10, 4);
        checks += 3;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL mid_second_strobes got %0d want 1", strobes - s0); end
        if (period !== 10) begin errors++; $display("FAIL mid_second_period got %0d want 10", period); end
        if (high_time !== 4) begin errors++; $display("FAIL mid_second_high got %0d want 4", high_time); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef PERIOD_AVG4_EN
        test_avg4;
`else
        test_steady;
        test_latency;
        test_loss;
        test_restart;
        test_boundary;
        test_reset_mid;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
